// File: rtl/line_fill_word_sel_if.sv
// ---------------------------------------------------------------------------
// line_fill_word_sel_if
//   Request/response bundle between the cache controller (master) and the
//   data-array word-select generator (slave).
//
//   Controller -> generator:
//     single_valid   single-word store request
//     single_offset  word offset of the single store
//     fill_start     begin a critical-word-first line fill
//     fill_offset    critical (first) word of the fill
//     beat_valid     memory returned one data word this cycle
//   Generator -> controller:
//     word_en        one-hot data-array write enable (or zero)
//     cur_offset     word pointer of the current fill beat
//     crit_beat      first beat of a fill is being written
//     busy           a fill is in progress
//     single_ready   single stores are accepted (~busy)
//     fill_done      one-cycle pulse after the last fill beat
// ---------------------------------------------------------------------------
interface line_fill_word_sel_if #(
  parameter int OFFSET_W = 5
);
  localparam int WORDS = 2 ** OFFSET_W;

  logic                single_valid;
  logic [OFFSET_W-1:0] single_offset;
  logic                fill_start;
  logic [OFFSET_W-1:0] fill_offset;
  logic                beat_valid;

  logic [WORDS-1:0]    word_en;
  logic [OFFSET_W-1:0] cur_offset;
  logic                crit_beat;
  logic                busy;
  logic                single_ready;
  logic                fill_done;

  modport master (
    output single_valid, single_offset, fill_start, fill_offset, beat_valid,
    input  word_en, cur_offset, crit_beat, busy, single_ready, fill_done
  );

  modport slave (
    input  single_valid, single_offset, fill_start, fill_offset, beat_valid,
    output word_en, cur_offset, crit_beat, busy, single_ready, fill_done
  );
endinterface

// File: rtl/line_fill_word_sel.sv
// ---------------------------------------------------------------------------
// line_fill_word_sel
//   Word-select generator for the cache data array.
//   IDLE: a single-word store produces a one-hot write enable for its offset.
//   FILL: a critical-word-first line fill walks a wrapping word pointer across
//         all WORDS words, one word per accepted memory beat, and pulses
//         fill_done for one cycle after the last beat.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  synchronous active-low reset
//     bus      line_fill_word_sel_if.slave (request inputs, select outputs)
// ---------------------------------------------------------------------------
module line_fill_word_sel #(
  parameter int OFFSET_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  line_fill_word_sel_if.slave   bus
);

  localparam int                  WORDS     = 2 ** OFFSET_W;
  localparam logic [OFFSET_W:0]   BEAT_LAST = (OFFSET_W+1)'(WORDS - 1);
  localparam logic [OFFSET_W-1:0] PTR_ONE   = OFFSET_W'(1);
  localparam logic [OFFSET_W:0]   CNT_ONE   = (OFFSET_W+1)'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t              r_state;
  logic [OFFSET_W-1:0] r_ptr;
  // One bit wider than the pointer so a complete fill can be counted.
  logic [OFFSET_W:0]   r_beat_cnt;
  logic                r_fill_done;

  logic                w_fill_beat;
  logic                w_last_beat;
  logic [WORDS-1:0]    w_word_en;

  assign w_fill_beat = (r_state == S_FILL) && bus.beat_valid;
  assign w_last_beat = w_fill_beat && (r_beat_cnt == BEAT_LAST);

  // Control state machine. The pointer wraps naturally at OFFSET_W bits,
  // which gives the critical-word-first order without a modulo.
  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values; reset is sampled synchronously at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_beat_cnt  <= '0;
      r_fill_done <= 1'b0;
    end else begin
      r_fill_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.fill_start) begin
            r_state    <= S_FILL;
            r_ptr      <= bus.fill_offset;
            r_beat_cnt <= '0;
          end
        end
        S_FILL: begin
          // Without beat_valid the fill stalls with pointer and count held.
          if (bus.beat_valid) begin
            r_ptr      <= r_ptr + PTR_ONE;
            r_beat_cnt <= r_beat_cnt + CNT_ONE;
            if (w_last_beat) begin
              r_state     <= S_IDLE;
              r_fill_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write enable. A fill beat and a single store can never coexist because
  // single stores are only honoured in IDLE, so at most one bit is set.
  // NOTE: the default assignment at the top keeps this block latch-free.
  always_comb begin
    w_word_en = '0;
    if (w_fill_beat) begin
      w_word_en[r_ptr] = 1'b1;
    end else if ((r_state == S_IDLE) && bus.single_valid) begin
      w_word_en[bus.single_offset] = 1'b1;
    end
  end

  assign bus.word_en      = w_word_en;
  assign bus.cur_offset   = r_ptr;
  assign bus.crit_beat    = w_fill_beat && (r_beat_cnt == '0);
  assign bus.busy         = (r_state == S_FILL);
  assign bus.single_ready = (r_state == S_IDLE);
  assign bus.fill_done    = r_fill_done;

endmodule

// File: tb/tb_line_fill_word_sel.sv
// ---------------------------------------------------------------------------
// tb_line_fill_word_sel
//   Drives three instances (OFFSET_W = 5, 3, 1) from one stimulus sequence;
//   `sel` picks which instance receives requests and whose outputs are
//   compared. Expected values come from the fill rule: beat k of a fill
//   starting at offset o writes word (o + k) mod WORDS.
// ---------------------------------------------------------------------------
module tb_line_fill_word_sel;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus, routed to the selected instance only.
  int         sel = 0;
  logic       single_valid = 1'b0;
  logic [4:0] single_offset = '0;
  logic       fill_start = 1'b0;
  logic [4:0] fill_offset = '0;
  logic       beat_valid = 1'b0;

  line_fill_word_sel_if #(.OFFSET_W(5)) bus5 ();
  line_fill_word_sel_if #(.OFFSET_W(3)) bus3 ();
  line_fill_word_sel_if #(.OFFSET_W(1)) bus1 ();

  assign bus5.single_valid  = single_valid && (sel == 0);
  assign bus5.single_offset = single_offset;
  assign bus5.fill_start    = fill_start && (sel == 0);
  assign bus5.fill_offset   = fill_offset;
  assign bus5.beat_valid    = beat_valid && (sel == 0);

  assign bus3.single_valid  = single_valid && (sel == 1);
  assign bus3.single_offset = single_offset[2:0];
  assign bus3.fill_start    = fill_start && (sel == 1);
  assign bus3.fill_offset   = fill_offset[2:0];
  assign bus3.beat_valid    = beat_valid && (sel == 1);

  assign bus1.single_valid  = single_valid && (sel == 2);
  assign bus1.single_offset = single_offset[0:0];
  assign bus1.fill_start    = fill_start && (sel == 2);
  assign bus1.fill_offset   = fill_offset[0:0];
  assign bus1.beat_valid    = beat_valid && (sel == 2);

  line_fill_word_sel #(.OFFSET_W(5)) u_dut5 (.clk(clk), .reset_n(reset_n), .bus(bus5));
  line_fill_word_sel #(.OFFSET_W(3)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));
  line_fill_word_sel #(.OFFSET_W(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  // Outputs of the selected instance, zero-extended.
  logic [63:0] o_word_en;
  logic [7:0]  o_cur;
  logic        o_crit, o_busy, o_ready, o_done;

  always_comb begin
    o_word_en = '0;
    o_cur     = '0;
    o_crit    = 1'b0;
    o_busy    = 1'b0;
    o_ready   = 1'b0;
    o_done    = 1'b0;
    case (sel)
      0: begin
        o_word_en = 64'(bus5.word_en); o_cur = 8'(bus5.cur_offset);
        o_crit = bus5.crit_beat; o_busy = bus5.busy;
        o_ready = bus5.single_ready; o_done = bus5.fill_done;
      end
      1: begin
        o_word_en = 64'(bus3.word_en); o_cur = 8'(bus3.cur_offset);
        o_crit = bus3.crit_beat; o_busy = bus3.busy;
        o_ready = bus3.single_ready; o_done = bus3.fill_done;
      end
      default: begin
        o_word_en = 64'(bus1.word_en); o_cur = 8'(bus1.cur_offset);
        o_crit = bus1.crit_beat; o_busy = bus1.busy;
        o_ready = bus1.single_ready; o_done = bus1.fill_done;
      end
    endcase
  end

  // Every fill_done pulse of the 32-word instance, for the end-of-run tally.
  int n_done5_seen = 0;
  always @(negedge clk) if (bus5.fill_done) n_done5_seen++;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done5 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int words_of(input int s);
    return (s == 0) ? 32 : (s == 1) ? 8 : 2;
  endfunction

  // Idle-state expectations of the selected instance (fill_done excluded).
  task automatic check_idle(input string tag);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_ready"}, o_ready, 1);
    check({tag, "_crit"},  o_crit, 0);
  endtask

  // Runs one fill on instance s from offset off.
  //   started:     the fill was already accepted by the caller
  //   mode:        0 random beats, 1 beat every cycle, 2 alternating 0/1
  //   abort_after: stop after this many beats (-1 = run to completion)
  // On completion it returns in the fill_done cycle, after checking it.
  // On abort it returns just after the edge that accepted the last beat.
  task automatic run_fill(input int s, input int off, input bit started,
                          input int mode, input int abort_after, output int cycles);
    int w, k, en_cnt, exp_ptr;
    bit bv;
    w = words_of(s);
    k = 0;
    en_cnt = 0;
    cycles = 0;
    sel = s;
    if (!started) begin
      fill_offset  = 5'(off);
      fill_start   = 1'b1;
      single_valid = 1'b0;
      beat_valid   = 1'b0;
      #3;
      check("start_idle_busy", o_busy, 0);
      check("start_no_en", o_word_en, 0);
      tick();
    end
    fill_start = 1'b0;
    while (k < w && k != abort_after) begin
      case (mode)
        0:       bv = ($urandom_range(0, 2) != 0);
        1:       bv = 1'b1;
        default: bv = cycles[0];
      endcase
      if (cycles > 4 * w) bv = 1'b1;
      beat_valid = bv;
      // Requests that must be ignored while filling.
      single_valid  = ($urandom_range(0, 3) == 0);
      single_offset = 5'($urandom);
      fill_start    = ($urandom_range(0, 7) == 0);
      fill_offset   = 5'($urandom);
      #3;
      exp_ptr = (off + k) % w;
      check("fill_cur_offset", o_cur, exp_ptr);
      check("fill_word_en", o_word_en, bv ? (64'd1 << exp_ptr) : 64'd0);
      check("fill_crit_beat", o_crit, bv && (k == 0));
      check("fill_busy", o_busy, 1);
      check("fill_ready", o_ready, 0);
      check("fill_no_done", o_done, 0);
      if (o_word_en != 0) en_cnt++;
      tick();
      cycles++;
      if (bv) k++;
    end
    beat_valid   = 1'b0;
    single_valid = 1'b0;
    fill_start   = 1'b0;
    if (k == w) begin
      #3;
      check("done_pulse", o_done, 1);
      check_idle("done");
      check("done_no_en", o_word_en, 0);
      check("done_ptr_wrapped", o_cur, off % w);
      check("fill_enable_count", en_cnt, w);
      if (s == 0) exp_done5++;
    end
  endtask

  int cyc;
  int off;

  initial begin
    // ---- reset ----
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    #3;
    check("rst_word_en", o_word_en, 0);
    check("rst_cur_offset", o_cur, 0);
    check("rst_done", o_done, 0);
    check_idle("rst");

    // ---- single writes ----
    tick();
    single_valid = 1'b1; single_offset = 5'd13;
    #3;
    check("single13_word_en", o_word_en, 64'h0000_2000);
    check("single13_busy", o_busy, 0);
    tick();
    single_valid = 1'b0;
    #3;
    check("single_off_word_en", o_word_en, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      single_valid = 1'b1; single_offset = 5'($urandom);
      #3;
      check("single_rand_word_en", o_word_en, 64'd1 << single_offset);
      check_idle("single_rand");
    end
    // beat_valid in IDLE must neither write nor move the pointer.
    tick();
    single_valid = 1'b0; beat_valid = 1'b1;
    #3;
    check("idle_beat_word_en", o_word_en, 0);
    tick();
    beat_valid = 1'b0;
    #3;
    check("idle_beat_cur", o_cur, 0);
    check_idle("idle_beat");

    // ---- wrapped fill from word 30 ----
    tick();
    run_fill(0, 30, 1'b0, 1, -1, cyc);
    check("wrap_fill_cycles", cyc, 32);
    tick(); #3;
    check("wrap_after_done", o_done, 0);
    check_idle("wrap_after");

    // ---- stalled fill from word 0, chained into a new fill ----
    tick();
    run_fill(0, 0, 1'b0, 2, -1, cyc);
    check("stall_fill_cycles", cyc, 64);
    // fill_start in the fill_done cycle is accepted.
    off = int'($urandom_range(0, 31));
    fill_offset = 5'(off); fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    #3;
    check("chain_busy", o_busy, 1);
    check("chain_cur", o_cur, off);
    run_fill(0, off, 1'b1, 0, -1, cyc);
    tick();

    // ---- collision: single store and fill_start together ----
    fill_start = 1'b1; fill_offset = 5'd7;
    single_valid = 1'b1; single_offset = 5'd5;
    #3;
    check("coll_word_en", o_word_en, 64'h20);
    check("coll_busy_now", o_busy, 0);
    tick();
    fill_start = 1'b0;
    #3;
    check("coll_busy_next", o_busy, 1);
    check("coll_cur", o_cur, 7);
    check("coll_single_blocked", o_word_en, 0);
    check("coll_ready", o_ready, 0);
    tick();
    single_valid = 1'b0;
    run_fill(0, 7, 1'b1, 0, -1, cyc);
    tick();

    // ---- mid-fill reset ----
    off = int'($urandom_range(0, 31));
    run_fill(0, off, 1'b0, 1, 10, cyc);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #3;
    check("mrst_busy", o_busy, 0);
    check("mrst_cur", o_cur, 0);
    check("mrst_word_en", o_word_en, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); #3;
      check("mrst_no_done", o_done, 0);
    end
    tick();
    run_fill(0, int'($urandom_range(0, 31)), 1'b0, 0, -1, cyc);
    tick();

    // ---- narrow instances ----
    run_fill(1, 5, 1'b0, 1, -1, cyc);
    check("w3_fill_cycles", cyc, 8);
    tick();
    run_fill(1, int'($urandom_range(0, 7)), 1'b0, 0, -1, cyc);
    tick();
    run_fill(2, 1, 1'b0, 1, -1, cyc);
    check("w1_fill_cycles", cyc, 2);
    tick();
    run_fill(2, 0, 1'b0, 2, -1, cyc);
    check("w1_stall_cycles", cyc, 4);
    tick();
    sel = 2; single_valid = 1'b1; single_offset = 5'd1;
    #3;
    check("w1_single_word_en", o_word_en, 64'h2);
    tick();
    single_valid = 1'b0;

    // ---- a few random fills on the 32-word line ----
    for (int i = 0; i < 3; i++) begin
      tick();
      run_fill(0, int'($urandom_range(0, 31)), 1'b0, 0, -1, cyc);
    end
    tick(); tick();
    check("done_pulse_total", n_done5_seen, exp_done5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_fill_word_sel.md
Name: line_fill_word_sel

Overview:
- Word-select generator for the cache data array; successor to the fixed 5-to-32 offset decoder.
- Parametrised in offset width.
- Single mode: one-hot write enable for a single-word store, same as the decoder.
- Fill mode: sequential critical-word-first line fill. Walks a wrapping word pointer across every word of the line, one word per accepted memory beat, then signals completion.

Parameters:
- OFFSET_W, 5, word-offset width; line holds WORDS = 2**OFFSET_W words (WORDS is derived, not overridable).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- single_valid  in  1  single-word write request (IDLE only)
- single_offset  in  OFFSET_W  word offset for single write
- fill_start  in  1  start line fill (sampled in IDLE only)
- fill_offset  in  OFFSET_W  critical (first) word offset of fill
- beat_valid  in  1  memory returned one data word this cycle (FILL only)
- word_en  out  WORDS  one-hot data-array write enable, or all zeros
- cur_offset  out  OFFSET_W  word pointer for the current fill beat
- crit_beat  out  1  high with the first fill beat's word_en
- busy  out  1  high while in FILL
- single_ready  out  1  equals ~busy
- fill_done  out  1  one-cycle registered pulse after the last beat

Behaviour:
- Reset (reset_n low at clk edge): state=IDLE, ptr=0, beat_cnt=0, fill_done=0.
- Outputs after reset: word_en=0, cur_offset=0, crit_beat=0, busy=0, single_ready=1.
- Reset mid-fill aborts with no fill_done pulse.
- States:
  - IDLE: busy=0.
  - FILL: busy=1.
- Transitions:
  - IDLE -> FILL on fill_start; ptr<=fill_offset, beat_cnt<=0.
  - FILL -> IDLE on the beat where beat_cnt==WORDS-1 and beat_valid=1; fill_done<=1 that edge, so it is high for exactly the following cycle.
- word_en (combinational from state/inputs/ptr):
  - IDLE: onehot(single_offset) when single_valid=1, else 0.
  - FILL: onehot(ptr) when beat_valid=1, else 0.
  - Never more than one bit set.
- cur_offset = ptr in both states.
- FILL beat handling:
  - On each beat_valid: ptr<=ptr+1 mod WORDS (natural OFFSET_W-bit wrap), beat_cnt<=beat_cnt+1.
  - beat_cnt is OFFSET_W+1 bits wide so it can count to WORDS.
- crit_beat = FILL & beat_valid & (beat_cnt==0).
- beat_valid low in FILL stalls: ptr and beat_cnt hold, word_en=0; no timeout.
- single_valid in FILL is ignored (single_ready=0); requester must hold the request.
- fill_start in FILL is ignored.
- beat_valid in IDLE is ignored.
- fill_start and single_valid together in IDLE: the single write is served that cycle (word_en=onehot(single_offset)); FILL starts the next cycle.
- fill_start in the same cycle as a fill_done pulse (state is already IDLE) is accepted normally.
- Latency: fill of WORDS beats with no stalls takes WORDS cycles in FILL. fill_done occurs 1 cycle after the last word_en.
- OFFSET_W=1 must work (2-word line, ptr toggles).

Test Plan:
- Reset/single write: reset_n low 2 cycles, then single_valid=1, single_offset=13. Required: word_en=32'h0000_2000 same cycle, busy=0; with single_valid=0, word_en=0.
- Wrapped fill: fill_start with fill_offset=30, then 32 consecutive beat_valid. Required: cur_offset sequence 30,31,0,1..29; crit_beat only on first beat (word_en=32'h4000_0000); fill_done high exactly 1 cycle after beat 32; busy then 0.
- Stalls: fill_offset=0, beat_valid alternates 1/0. Required: word_en=0 and ptr held on idle cycles; 32 enables total; fill_done after 64 cycles in FILL.
- Collision: IDLE with fill_start=1, single_valid=1, single_offset=5, fill_offset=7. Required: word_en=32'h20 that cycle; next cycle busy=1, cur_offset=7. Later single_valid during FILL gives no word_en and single_ready=0.
- Mid-fill reset: after 10 beats of a fill, pulse reset_n low. Required: busy=0, cur_offset=0, no fill_done ever asserted; a new fill then runs correctly.
- Parameter sweep OFFSET_W=1 and 3: full fills from offsets 1 and 5 wrap correctly, with 2 and 8 beats respectively.
